// File: rtl/my_ram_pkg.sv
// Shared types and defaults for the RAM scan controller slice.
package my_ram_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int RAM_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2
  } state_t;

  // One bit per request line, used both for the delayed copy and the edges.
  typedef struct packed {
    logic wr;
    logic fill;
    logic scan;
  } req_t;

endpackage

// File: rtl/my_ram_scan_ctrl_if.sv
// RAM port bundle between the scan controller (master) and the 32x4 RAM (slave).
interface my_ram_scan_ctrl_if
  import my_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output ram_addr,
    output ram_data,
    output ram_wren,
    input  ram_q
  );

  modport slave (
    input  ram_addr,
    input  ram_data,
    input  ram_wren,
    output ram_q
  );

endinterface

// File: rtl/my_tick_div.sv
// Free-running step divider: one-cycle tick every TICK_DIV clocks while clr is low.
module my_tick_div #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clr && (cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/my_ram_scan_ctrl.sv
// Address/data sequencer for the 32x4 RAM: manual write, 32-word fill, timed scan.
// Optional SCAN_PINGPONG_EN makes the scan bounce between the ends instead of wrapping.
module my_ram_scan_ctrl
  import my_ram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   sw_addr,
  input  logic [DATA_W-1:0]   sw_data,
  input  logic                wr_req,
  input  logic                fill_req,
  input  logic                scan_req,
  input  logic                stop,
  my_ram_scan_ctrl_if.master  ram,
  output logic [ADDR_W-1:0]   disp_addr,
  output logic [DATA_W-1:0]   disp_data,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, next_state;
  req_t              req_now, req_d, req_edge;
  logic              armed;
  logic              tick, tick_clr;

  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              wren_q, wren_nxt;
  logic [DATA_W-1:0] seed, seed_nxt;

  logic              tag_v;
  logic [ADDR_W-1:0] tag_addr;

`ifdef SCAN_PINGPONG_EN
  logic              dir_up, dir_nxt;
`endif

  // Request edge detection. The first clock after reset only loads the
  // delayed copy, so a request held high through reset never fires.
  assign req_now  = {wr_req, fill_req, scan_req};
  assign req_edge = armed ? (req_now & ~req_d) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d <= '0;
      armed <= 1'b0;
    end else begin
      req_d <= req_now;
      armed <= 1'b1;
    end
  end

  // Counter stays cleared outside SCAN and on the entry/exit edges.
  assign tick_clr = (state != SCAN) || (next_state != SCAN);

  my_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // Priority fill > scan > wr; stop overrides every request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!stop) begin
          if (req_edge.fill)      next_state = FILL;
          else if (req_edge.scan) next_state = SCAN;
        end
      end
      FILL: begin
        if (stop || addr_q == ADDR_MAX) next_state = IDLE;
      end
      SCAN: begin
        if (stop)               next_state = IDLE;
        else if (req_edge.fill) next_state = FILL;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    addr_nxt = sw_addr;
    data_nxt = sw_data;
    wren_nxt = 1'b0;
    seed_nxt = seed;
`ifdef SCAN_PINGPONG_EN
    dir_nxt  = dir_up;
`endif
    case (next_state)
      FILL: begin
        seed_nxt = (state == FILL) ? seed : sw_data;
        addr_nxt = (state == FILL) ? addr_q + 1'b1 : '0;
        data_nxt = seed_nxt + DATA_W'(addr_nxt);
        wren_nxt = 1'b1;
      end
      SCAN: begin
        data_nxt = data_q;
        if (state != SCAN) begin
          addr_nxt = '0;
`ifdef SCAN_PINGPONG_EN
          dir_nxt  = 1'b1;
`endif
        end else if (tick) begin
`ifdef SCAN_PINGPONG_EN
          if (dir_up) begin
            if (addr_q == ADDR_MAX) begin
              addr_nxt = addr_q - 1'b1;
              dir_nxt  = 1'b0;
            end else begin
              addr_nxt = addr_q + 1'b1;
            end
          end else begin
            if (addr_q == '0) begin
              addr_nxt = addr_q + 1'b1;
              dir_nxt  = 1'b1;
            end else begin
              addr_nxt = addr_q - 1'b1;
            end
          end
`else
          addr_nxt = addr_q + 1'b1;
`endif
        end else begin
          addr_nxt = addr_q;
        end
      end
      default: begin
        // Staying in IDLE means no fill/scan edge won and stop is low.
        wren_nxt = (state == IDLE) && !stop && req_edge.wr;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
      seed   <= '0;
    end else begin
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      wren_q <= wren_nxt;
      seed   <= seed_nxt;
    end
  end

`ifdef SCAN_PINGPONG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dir_up <= 1'b1;
    else       dir_up <= dir_nxt;
  end
`endif

  assign ram.ram_addr = addr_q;
  assign ram.ram_data = data_q;
  assign ram.ram_wren = wren_q;

  // Readback: tag follows the address the RAM samples, then pairs with ram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v     <= 1'b0;
      tag_addr  <= '0;
      disp_addr <= '0;
      disp_data <= '0;
    end else begin
      tag_v    <= 1'b1;
      tag_addr <= addr_q;
      if (tag_v) begin
        disp_addr <= tag_addr;
        disp_data <= ram.ram_q;
      end
    end
  end

endmodule

// File: doc/my_ram_scan_ctrl.md
Name: my_ram_scan_ctrl

Overview:
- Address/data sequencer that sits directly upstream of the 32x4 synchronous RAM (registered read, write-first on posedge).
- Drives the RAM address, data and write-enable. Provides three operations: a manual single write from the switches, an automatic 32-word fill, and a timed read-scan.
- Captures the RAM read data back, aligned with its address, for the hex display stage.

Parameters:
- ADDR_W, 5, RAM address width (depth 2^ADDR_W).
- DATA_W, 4, RAM word width.
- TICK_DIV, 50000000, clk cycles per scan step (1 Hz at 50 MHz); minimum value 3.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- sw_addr  in  ADDR_W  manual address.
- sw_data  in  DATA_W  manual write data / fill seed.
- wr_req  in  1  level; each rising edge requests one write.
- fill_req  in  1  level; each rising edge starts a fill.
- scan_req  in  1  level; each rising edge starts a scan.
- stop  in  1  level; while high, aborts fill/scan.
- ram_q  in  DATA_W  RAM read data (valid 1 cycle after the address is sampled).
- ram_addr  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM write enable.
- disp_addr  out  ADDR_W  address whose data is on disp_data.
- disp_data  out  DATA_W  captured RAM word.
- busy  out  1  high in FILL or SCAN.

Behaviour:
- Reset values:
  - state IDLE.
  - ram_addr, ram_data, disp_addr and disp_data all 0.
  - ram_wren 0, busy 0.
  - Edge-detect registers 0, so a request input held high through reset does not fire.
  - Tick counter 0.
- All outputs are registered.
- Request edges: detect on a 1-cycle delayed copy (in & ~in_d).
- Priority when edges coincide: fill > scan > wr. stop overrides all three.
- IDLE:
  - ram_addr <= sw_addr; ram_data <= sw_data.
  - ram_wren <= 1 for exactly one cycle on a wr edge, else 0.
- FILL:
  - Entered on a fill edge. ram_addr steps 0..2^ADDR_W-1, one per cycle, with ram_wren=1.
  - ram_data = (sw_data, latched at entry) + ram_addr[DATA_W-1:0], mod 2^DATA_W.
  - Takes exactly 32 write cycles, then IDLE with ram_wren=0 in the next cycle.
  - New fill/scan/wr edges are ignored during FILL.
  - stop high: ram_wren=0 from the next cycle, return to IDLE; words already written stay.
- SCAN:
  - Entered on a scan edge. ram_wren=0 throughout; ram_addr starts at 0.
  - The tick counter counts 0..TICK_DIV-1. At terminal count, ram_addr advances with wrap 2^ADDR_W-1 -> 0.
  - Runs until stop.
  - A wr edge during SCAN is ignored. A fill edge aborts SCAN and enters FILL.
- Readback pipeline:
  - Every cycle, a valid/address tag is delayed 2 stages behind ram_addr (RAM sample edge + capture edge).
  - disp_addr/disp_data update together, two cycles after ram_addr changes, so they are never mismatched.
  - Readback also runs in IDLE, so the display shows the word at sw_addr with 2-cycle latency.
- busy = (state != IDLE), registered with the state.
- Reset mid-FILL/SCAN: immediate return to IDLE and zeros; any remaining fill writes are never issued.
- Tick counter clears on SCAN entry and in every non-SCAN state.

Optional Feature:
- Macro: SCAN_PINGPONG_EN.
- Defined: SCAN direction reverses at the ends: 0,1,...,31,30,...,1,0,1,... A direction flag resets to up and is set to up on each SCAN entry.
- Undefined: up-count with wrap 31 -> 0 only; no direction register exists.

Decomposition:
- Package my_ram_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum: IDLE=2'd0, FILL=2'd1, SCAN=2'd2.
  - RAM_DEPTH = 1<<ADDR_W.
- One natural sub-module: my_tick_div.
  - Parameterised by TICK_DIV; inputs clk, reset, clr; output a 1-cycle tick pulse.
  - Reused by other board-level timed blocks.

Test Plan:
- Write and readback (TICK_DIV=4): reset; sw_addr=5, sw_data=9, pulse wr_req.
  - Expect ram_wren high exactly 1 cycle with ram_addr=5, ram_data=9.
  - 2 cycles later, expect disp_addr=5, disp_data=9.
- Fill: sw_data=3, fill_req edge.
  - Expect 32 consecutive writes with addr k and data (3+k)&15, then busy=0.
  - Memory model check: word 13 = 0, word 31 = 2.
- Scan timing: after the fill, scan_req edge.
  - Expect ram_addr to advance every 4 cycles: 0,1,...,31,0 (pingpong build: 31,30).
  - disp_data tracks (3+disp_addr)&15 at 2-cycle lag.
- Simultaneous requests: fill_req, scan_req and wr_req rise in the same cycle.
  - Expect FILL entered and no single-write cycle.
  - Repeat with stop high: expect state stays IDLE and no writes.
- Stop mid-fill: raise stop after 10 write cycles.
  - Expect ram_wren 0 from the next cycle and busy 0; words 10..31 keep their old contents.
- Async reset mid-scan: assert reset between clock edges at ram_addr=7.
  - Expect all outputs 0 immediately. scan_req held high through reset release must not restart SCAN.
